// File: rtl/sliding_window_buffer.sv
// sliding_window_buffer
//
// Holds a WIN x WIN window of PIXEL_W-bit pixels. The window can be loaded
// from scratch (LOAD) or moved by one pixel left, right or down. A move shifts
// the existing contents on the edge that accepts the command. The freed column
// or row is then filled from the pixel stream.
//
// Parameters
//   PIXEL_W      bits per pixel
//   WIN          window edge length; must be odd and in the range 3..7
//
// Ports
//   clk          sole clock, rising edge
//   n_rst        asynchronous active-low reset
//   cmd_valid    command offered
//   cmd_ready    command accepted when cmd_valid & cmd_ready (IDLE only)
//   cmd_op       00 LOAD, 01 SHIFT_LEFT, 10 SHIFT_RIGHT, 11 SHIFT_DOWN
//   abort        cancels an in-progress fill and clears the window
//   pix_valid    pixel offered
//   pix_ready    pixel accepted when pix_valid & pix_ready (FILL only)
//   pix_data     pixel value
//   window_out   element k = r*WIN + c at bits [k*PIXEL_W +: PIXEL_W]
//   window_valid window_out holds a completed window
//   done         one-cycle pulse when an operation completes
//   busy         high whenever the block is not idle
module sliding_window_buffer #(
  parameter int unsigned PIXEL_W = 8,
  parameter int unsigned WIN     = 3
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic                         abort,
  input  logic                         pix_valid,
  output logic                         pix_ready,
  input  logic [PIXEL_W-1:0]           pix_data,
  output logic [WIN*WIN*PIXEL_W-1:0]   window_out,
  output logic                         window_valid,
  output logic                         done,
  output logic                         busy
);

  // Reject unsupported window sizes at elaboration time.
  if (WIN < 3 || WIN > 7 || (WIN % 2) == 0) begin : g_bad_win
    $error("sliding_window_buffer: WIN must be odd and within 3..7");
  end

  localparam int unsigned NELEM = WIN * WIN;
  localparam int unsigned CNT_W = $clog2(NELEM + 1);

  localparam logic [1:0] OpLoad  = 2'b00;
  localparam logic [1:0] OpLeft  = 2'b01;
  localparam logic [1:0] OpRight = 2'b10;
  localparam logic [1:0] OpDown  = 2'b11;

  localparam logic [CNT_W-1:0] LastLoad = CNT_W'(NELEM - 1);
  localparam logic [CNT_W-1:0] LastLine = CNT_W'(WIN - 1);

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDone
  } state_e;

  state_e             r_state, w_state_d;
  logic [1:0]         r_op, w_op_d;
  logic [CNT_W-1:0]   r_cnt, w_cnt_d;
  logic               r_valid, w_valid_d;
  logic [PIXEL_W-1:0] r_win   [NELEM];
  logic [PIXEL_W-1:0] w_win_d [NELEM];

  logic w_cmd_hs;
  logic w_pix_hs;
  logic w_last;
  int   w_cnt_int;
  int   w_slot;

  // cmd_ready is masked by reset so it reads 0 while n_rst is held low.
  assign cmd_ready    = n_rst & (r_state == StIdle);
  assign pix_ready    = (r_state == StFill);
  assign busy         = (r_state != StIdle);
  assign done         = (r_state == StDone);
  assign window_valid = r_valid;

  assign w_cmd_hs = cmd_valid & cmd_ready;
  assign w_pix_hs = pix_valid & pix_ready;

  // A LOAD takes a full window of pixels; every move takes one row or column.
  assign w_last    = (r_op == OpLoad) ? (r_cnt == LastLoad) : (r_cnt == LastLine);
  assign w_cnt_int = int'(r_cnt);

  // Destination slot of the next accepted pixel.
  always_comb begin
    w_slot = 0;
    unique case (r_op)
      OpLoad:  w_slot = w_cnt_int;
      OpLeft:  w_slot = w_cnt_int * int'(WIN) + int'(WIN) - 1;
      OpRight: w_slot = w_cnt_int * int'(WIN);
      OpDown:  w_slot = w_cnt_int;
      default: w_slot = 0;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    w_op_d    = r_op;
    w_cnt_d   = r_cnt;
    w_valid_d = r_valid;
    for (int k = 0; k < NELEM; k++) begin
      w_win_d[k] = r_win[k];
    end

    unique case (r_state)
      StIdle: begin
        if (w_cmd_hs) begin
          w_op_d    = cmd_op;
          w_cnt_d   = '0;
          w_valid_d = 1'b0;
          w_state_d = StFill;
          // Moves shift the old contents on the accepting edge; the vacated
          // column or row is zeroed until the new pixels arrive.
          unique case (cmd_op)
            OpLeft: begin
              for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN - 1; c++) begin
                  w_win_d[r*WIN+c] = r_win[r*WIN+c+1];
                end
                w_win_d[r*WIN+WIN-1] = '0;
              end
            end
            OpRight: begin
              for (int r = 0; r < WIN; r++) begin
                for (int c = 1; c < WIN; c++) begin
                  w_win_d[r*WIN+c] = r_win[r*WIN+c-1];
                end
                w_win_d[r*WIN] = '0;
              end
            end
            OpDown: begin
              for (int r = 1; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                  w_win_d[r*WIN+c] = r_win[(r-1)*WIN+c];
                end
              end
              for (int c = 0; c < WIN; c++) begin
                w_win_d[c] = '0;
              end
            end
            default: begin
              // LOAD keeps the old contents until each slot is overwritten.
            end
          endcase
        end
      end

      StFill: begin
        if (abort) begin
          // Abort beats a simultaneous pixel handshake; that pixel is dropped.
          for (int k = 0; k < NELEM; k++) begin
            w_win_d[k] = '0;
          end
          w_valid_d = 1'b0;
          w_cnt_d   = '0;
          w_state_d = StIdle;
        end else if (w_pix_hs) begin
          for (int k = 0; k < NELEM; k++) begin
            if (k == w_slot) begin
              w_win_d[k] = pix_data;
            end
          end
          if (w_last) begin
            w_cnt_d   = '0;
            w_valid_d = 1'b1;
            w_state_d = StDone;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
      end

      StDone: begin
        w_state_d = StIdle;
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= StIdle;
      r_op    <= OpLoad;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      for (int k = 0; k < NELEM; k++) begin
        r_win[k] <= '0;
      end
    end else begin
      r_state <= w_state_d;
      r_op    <= w_op_d;
      r_cnt   <= w_cnt_d;
      r_valid <= w_valid_d;
      for (int k = 0; k < NELEM; k++) begin
        r_win[k] <= w_win_d[k];
      end
    end
  end

  for (genvar k = 0; k < NELEM; k++) begin : g_pack
    assign window_out[k*PIXEL_W +: PIXEL_W] = r_win[k];
  end

endmodule
